// File: rtl/zeroheti_mtimer.sv
// APB machine timer: 64-bit prescaled mtime, 64-bit compare, level interrupt.
// LO-then-HI reads of mtime are made atomic through a shadow of the high word.
module zeroheti_mtimer #(
    parameter int unsigned AddrWidth  = 12,
    parameter int unsigned PrescWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic [63:0]          mtime_o,
    output logic                 irq_o
);

    localparam logic [2:0] SelMtimeLo = 3'd0;
    localparam logic [2:0] SelMtimeHi = 3'd1;
    localparam logic [2:0] SelCmpLo   = 3'd2;
    localparam logic [2:0] SelCmpHi   = 3'd3;
    localparam logic [2:0] SelCtrl    = 3'd4;
    localparam logic [2:0] SelStatus  = 3'd5;

    logic [63:0]           mtime;
    logic [63:0]           cmp;
    logic [31:0]           shadow_hi;
    logic                  en;
    logic [PrescWidth-1:0] presc;
    logic [PrescWidth-1:0] presc_cnt;
    logic                  irq;

    logic                  xfer;
    logic                  bad_addr;
    logic                  rd_en;
    logic                  wr_en;
    logic [2:0]            sel;
    logic                  tick;
    logic [31:0]           ctrl_rd;
    logic [31:0]           rdata;
    logic [PrescWidth-1:0] presc_nx;
    logic                  unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    // A transfer under reset is dropped entirely: no read data, no error, no write.
    assign xfer        = psel_i & penable_i & ~rst_i;
    assign bad_addr    = (paddr_i[1:0] != 2'b00) | (paddr_i[4:3] == 2'b11);
    assign sel         = paddr_i[4:2];
    assign rd_en       = xfer & ~bad_addr & ~pwrite_i;
    assign wr_en       = xfer & ~bad_addr & pwrite_i;
    assign unused_addr = ^paddr_i[AddrWidth-1:5];

    assign tick = en & (presc_cnt == presc);

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[0] = en;
        ctrl_rd[8 +: PrescWidth] = presc;
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SelMtimeLo: rdata = mtime[31:0];
            SelMtimeHi: rdata = shadow_hi;
            SelCmpLo:   rdata = cmp[31:0];
            SelCmpHi:   rdata = cmp[63:32];
            SelCtrl:    rdata = ctrl_rd;
            SelStatus:  rdata = {31'd0, irq};
            default:    rdata = '0;
        endcase
    end

    // PRESC bit i lives at CTRL bit 8+i, so its byte strobe is (8+i)/8.
    always_comb begin
        presc_nx = presc;
        for (int i = 0; i < int'(PrescWidth); i++) begin
            if (pstrb_i[(8 + i) / 8]) presc_nx[i] = pwdata_i[8 + i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime     <= '0;
            cmp       <= '1;
            shadow_hi <= '0;
            en        <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            // A software write to either mtime half wins over the tick, no carry.
            if (wr_en && sel == SelMtimeLo) begin
                mtime[31:0] <= merge(mtime[31:0], pwdata_i, pstrb_i);
            end else if (wr_en && sel == SelMtimeHi) begin
                mtime[63:32] <= merge(mtime[63:32], pwdata_i, pstrb_i);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_en && sel == SelCtrl) begin
                presc_cnt <= '0;
                if (pstrb_i[0]) en <= pwdata_i[0];
                presc <= presc_nx;
            end else if (en) begin
                presc_cnt <= tick ? '0 : presc_cnt + PrescWidth'(1);
            end

            if (wr_en && sel == SelCmpLo) cmp[31:0]  <= merge(cmp[31:0], pwdata_i, pstrb_i);
            if (wr_en && sel == SelCmpHi) cmp[63:32] <= merge(cmp[63:32], pwdata_i, pstrb_i);

            if (rd_en && sel == SelMtimeLo) shadow_hi <= mtime[63:32];

            irq <= en & (mtime >= cmp);
        end
    end

    assign prdata_o  = rd_en ? rdata : '0;
    assign pslverr_o = xfer & bad_addr;
    assign pready_o  = 1'b1;
    assign mtime_o   = mtime;
    assign irq_o     = irq;

endmodule

// File: doc/zeroheti_mtimer.md
ZEROHETI_MTIMER -- requirements
Module: zeroheti_mtimer

Interface
REQ-001 SHALL have parameter AddrWidth, default 12: APB address width; only paddr[4:2] are decoded.
REQ-002 SHALL have parameter PrescWidth, default 8: width of the prescaler field and its counter.
REQ-003 SHALL have port clk_i, input, 1: single clock for all state.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port psel_i, input, 1: APB select.
REQ-006 SHALL have port penable_i, input, 1: APB enable.
REQ-007 SHALL have port pwrite_i, input, 1: APB write.
REQ-008 SHALL have port paddr_i, input, AddrWidth: APB address.
REQ-009 SHALL have port pwdata_i, input, 32: APB write data.
REQ-010 SHALL have port pstrb_i, input, 4: APB byte strobes.
REQ-011 SHALL have port prdata_o, output, 32: APB read data.
REQ-012 SHALL have port pready_o, output, 1: APB ready.
REQ-013 SHALL have port pslverr_o, output, 1: APB error.
REQ-014 SHALL have port mtime_o, output, 64: free-running time base. It drives the core's mtime_i input.
REQ-015 SHALL have port irq_o, output, 1: level timer interrupt. It drives one ext_irqs_i line.

Function
REQ-016 A transfer SHALL occur in any cycle with psel_i&penable_i. pready_o SHALL be constantly 1, giving zero wait states.
REQ-017 Register map, offset = paddr_i[4:0]:
- 0x00 MTIME_LO (rw)
- 0x04 MTIME_HI (rw)
- 0x08 CMP_LO (rw)
- 0x0C CMP_HI (rw)
- 0x10 CTRL (rw): bit0 EN; bits[8+PrescWidth-1:8] PRESC
- 0x14 STATUS (ro): bit0 = irq_o
REQ-018 An offset that is unmapped (0x18-0x1F) or has paddr_i[1:0]!=0 SHALL give pslverr_o=1 and prdata_o=0, and the write SHALL be ignored. Otherwise pslverr_o=0.
REQ-019 Writes SHALL update only the bytes enabled by pstrb_i. CTRL bits that do not exist SHALL read 0. Writes to STATUS SHALL be ignored with no error.
REQ-020 prdata_o SHALL be combinational from register state during the access phase, and 0 when no transfer is in progress.
REQ-021 The prescaler counter presc_cnt SHALL behave as follows while EN=1:
- If presc_cnt==PRESC: presc_cnt<=0 and mtime increments by 1.
- Otherwise: presc_cnt increments by 1.
- Consequence: PRESC=0 increments mtime every cycle; PRESC=N increments it every N+1 cycles.
REQ-022 While EN=0, mtime and presc_cnt SHALL hold. Writing CTRL SHALL clear presc_cnt to 0.
REQ-023 mtime SHALL be a 64-bit counter that wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-024 A write to MTIME_LO or MTIME_HI SHALL replace the addressed half and suppress the increment in that cycle. The other half SHALL be unchanged, with no carry.
REQ-025 A read of MTIME_LO SHALL return mtime[31:0] and latch mtime[63:32] into shadow_hi in the same cycle. A read of MTIME_HI SHALL return shadow_hi. This makes a LO-then-HI read sequence atomic.
REQ-026 irq_o SHALL be registered: irq_o <= EN & (mtime >= cmp), 64-bit unsigned compare, using register values of the current cycle. This gives one-cycle latency from a register change to irq_o.
REQ-027 irq_o SHALL stay asserted until cmp is raised above mtime, EN is cleared, or mtime wraps below cmp. There SHALL be no pulse or sticky behaviour.
REQ-028 mtime_o SHALL equal the mtime register directly, with no added delay.

Reset
REQ-029 On a clk_i edge with rst_i=1, the block SHALL set:
- mtime=0, presc_cnt=0, shadow_hi=0
- cmp=0xFFFF_FFFF_FFFF_FFFF
- EN=0, PRESC=0
- irq_o=0
REQ-030 During reset, prdata_o and pslverr_o SHALL be 0 and pready_o SHALL be 1. Reset asserted mid-transfer SHALL discard that transfer.

Verification
REQ-031 Prescale: PRESC=3, EN=1 from mtime=0 -> after 20 cycles mtime_o=5. A CTRL write restarts presc_cnt at 0.
REQ-032 Compare:
- Setup: cmp=10, PRESC=0, EN=1, mtime=0.
- irq_o=1 exactly one cycle after mtime_o reaches 10.
- Writing CMP_LO=100 drops irq_o on the next cycle.
REQ-033 Atomic read:
- Setup: mtime=0x0000_0000_FFFF_FFFE, EN=1, PRESC=0.
- Read LO -> 0xFFFF_FFFE.
- Read HI two cycles later -> 0x0000_0000, not 0x0000_0001.
REQ-034 Wrap: mtime=0xFFFF_FFFF_FFFF_FFFF, cmp=0xFFFF_FFFF_FFFF_FFFF, EN=1 -> next cycle mtime_o=0; irq_o=1 then 0.
REQ-035 Strobes and errors:
- Write CMP_LO=0xAABBCCDD with pstrb=0b0101 over 0xFFFF_FFFF -> reads 0xFFBBFFDD.
- Access to offset 0x18 -> pslverr_o=1, prdata_o=0, no state change.
REQ-036 Mid-run reset: rst_i=1 for one cycle while EN=1 and irq_o=1 -> all REQ-029 values on the next cycle, and mtime_o stays 0.
